spi_sipo_rx: RTL and testbench

//   SPI receive-side deserializer; the counterpart of the PISO transmit shifter in Modul SPI.

---
 rtl/spi_sipo_rx.sv | 158 +++++++++++++++
 tb/tb_spi_sipo_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_sipo_rx.sv
// SPI receive deserializer: oversamples SCK/SER_IN/ENABLE on CLK, shifts LSB first, and
// presents words with a VALID/ACK hold handshake. Optional sticky overrun via SPI_RX_OVERRUN_EN.
module spi_sipo_rx #(
  parameter int D_Pack   = 8,
  parameter int SYNC_STG = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCK,
  input  logic              SER_IN,
  input  logic              ENABLE,
  input  logic              C_PH,
  output logic [D_Pack-1:0] DATA_OUT,
  output logic              DATA_VALID,
  input  logic              DATA_ACK,
  output logic              BUSY,
  output logic              FRAME_ERR
`ifdef SPI_RX_OVERRUN_EN
  ,
  output logic              OVERRUN
`endif
);

  localparam int CW = $clog2(D_Pack);
  localparam logic [CW-1:0] LAST_CNT = CW'(D_Pack - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STG-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STG-1:0] ser_sync_q, ser_sync_d;
  logic [SYNC_STG-1:0] en_sync_q,  en_sync_d;
  logic                sck_prev_q, sck_prev_d;
  state_t              state_q, state_d;
  logic [D_Pack-1:0]   sh_q, sh_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [D_Pack-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
`ifdef SPI_RX_OVERRUN_EN
  logic                ovr_q, ovr_d;
`endif

  logic sck_s, ser_s, en_s, sample_edge;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STG-2:0], SCK};
    ser_sync_d  = {ser_sync_q[SYNC_STG-2:0], SER_IN};
    en_sync_d   = {en_sync_q[SYNC_STG-2:0], ENABLE};
    sck_s       = sck_sync_q[SYNC_STG-1];
    ser_s       = ser_sync_q[SYNC_STG-1];
    en_s        = en_sync_q[SYNC_STG-1];
    sck_prev_d  = sck_s;
    // Sample on the edge opposite the transmitter's launch edge.
    sample_edge = C_PH ? (sck_prev_q & ~sck_s) : (~sck_prev_q & sck_s);
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!en_s) state_d = SHIFT;
      end
      SHIFT: begin
        // Deselect wins over a coincident sample edge.
        if (en_s) begin
          state_d = IDLE;
          cnt_d   = '0;
          ferr_d  = (cnt_q != '0);
        end else if (sample_edge) begin
          sh_d = {ser_s, sh_q[D_Pack-1:1]};
          if (cnt_q == LAST_CNT) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
`ifdef SPI_RX_OVERRUN_EN
    ovr_d   = ovr_q;
`endif
    if (DATA_ACK && valid_q) begin
      valid_d = 1'b0;
`ifdef SPI_RX_OVERRUN_EN
      ovr_d   = 1'b0;
`endif
    end
    if (done_q) begin
`ifdef SPI_RX_OVERRUN_EN
      // Unread word is protected; the incoming one is lost.
      if (valid_q && !DATA_ACK) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = sh_q;
        valid_d = 1'b1;
      end
`else
      data_d  = sh_q;
      valid_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sck_sync_q <= '0;
      ser_sync_q <= '0;
      en_sync_q  <= '0;
      sck_prev_q <= 1'b0;
      state_q    <= IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef SPI_RX_OVERRUN_EN
      ovr_q      <= 1'b0;
`endif
    end else begin
      sck_sync_q <= sck_sync_d;
      ser_sync_q <= ser_sync_d;
      en_sync_q  <= en_sync_d;
      sck_prev_q <= sck_prev_d;
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
`ifdef SPI_RX_OVERRUN_EN
      ovr_q      <= ovr_d;
`endif
    end
  end

  assign DATA_OUT   = data_q;
  assign DATA_VALID = valid_q;
  assign BUSY       = (state_q == SHIFT);
  assign FRAME_ERR  = ferr_q;
`ifdef SPI_RX_OVERRUN_EN
  assign OVERRUN    = ovr_q;
`endif

endmodule

// File: tb/tb_spi_sipo_rx.sv
// Directed bench for spi_sipo_rx: both phases, back-to-back words, aborted frame,
// ACK/completion collision, overwrite/overrun and mid-frame reset.
module tb_spi_sipo_rx;
  localparam int H = 6;  // SCK half period in CLK cycles

  logic       clk, rst, sck, ser_in, enable, c_ph, data_ack;
  logic [7:0] data_out;
  logic       data_valid, busy, frame_err;
`ifdef SPI_RX_OVERRUN_EN
  logic       overrun;
`endif

  int vectors = 0;
  int miscompares = 0;
  int fe_count = 0;
  int fe_base;

  spi_sipo_rx #(.D_Pack(8), .SYNC_STG(2)) dut (
    .CLK(clk), .RST(rst), .SCK(sck), .SER_IN(ser_in), .ENABLE(enable), .C_PH(c_ph),
    .DATA_OUT(data_out), .DATA_VALID(data_valid), .DATA_ACK(data_ack),
    .BUSY(busy), .FRAME_ERR(frame_err)
`ifdef SPI_RX_OVERRUN_EN
    , .OVERRUN(overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err === 1'b1) fe_count <= fe_count + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int n, input logic cph);
    for (int i = 0; i < n; i++) begin
      if (cph) begin
        sck = 1'b1; ser_in = d[i]; tick(H);
        sck = 1'b0;
        if (i != n - 1) tick(H);
      end else begin
        ser_in = d[i]; tick(H);
        sck = 1'b1; tick(H);
        sck = 1'b0;
      end
    end
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1; tick(1); data_ack = 1'b0;
  endtask

  task automatic end_frame();
    tick(H); enable = 1'b1; tick(4);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sck = 1'b0; ser_in = 1'b0; enable = 1'b1; c_ph = 1'b1; data_ack = 1'b0;
    tick(3);
    chk("rst_valid", {31'd0, data_valid}, 0);
    chk("rst_data",  {24'd0, data_out}, 0);
    chk("rst_busy",  {31'd0, busy}, 0);
    rst = 1'b0;
    tick(4);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_ferr", {31'd0, frame_err}, 0);

    // 1: C_PH=1, A5, latency SYNC_STG+2 from last SCK fall
    enable = 1'b0; tick(4);
    chk("t1_busy", {31'd0, busy}, 1);
    send_bits(8'hA5, 8, 1'b1);
    tick(3);
    chk("t1_valid_early", {31'd0, data_valid}, 0);
    tick(1);
    chk("t1_valid", {31'd0, data_valid}, 1);
    chk("t1_data", {24'd0, data_out}, 32'hA5);
    ack_pulse();
    chk("t1_ack_clr", {31'd0, data_valid}, 0);
    end_frame();
    chk("t1_end_busy", {31'd0, busy}, 0);

    // 2: C_PH=0, back-to-back 3C, C3 with ACK each
    c_ph = 1'b0; fe_base = fe_count;
    enable = 1'b0; tick(4);
    fork
      begin
        send_bits(8'h3C, 8, 1'b0);
        send_bits(8'hC3, 8, 1'b0);
      end
      begin
        logic [7:0] expw [2];
        expw[0] = 8'h3C; expw[1] = 8'hC3;
        for (int w = 0; w < 2; w++) begin
          int k = 0;
          while (data_valid !== 1'b1 && k < 400) begin tick(1); k++; end
          chk("t2_wait_valid", {31'd0, data_valid}, 1);
          chk("t2_data", {24'd0, data_out}, {24'd0, expw[w]});
          ack_pulse();
          chk("t2_ack_clr", {31'd0, data_valid}, 0);
        end
      end
    join
    end_frame();
    chk("t2_no_ferr", fe_count - fe_base, 0);

    // 3: abort after 5 bits of FF, then 12
    c_ph = 1'b1; fe_base = fe_count;
    enable = 1'b0; tick(4);
    send_bits(8'hFF, 5, 1'b1);
    tick(H);
    enable = 1'b1;
    tick(3);
    chk("t3_ferr_pulse", {31'd0, frame_err}, 1);
    chk("t3_busy_off", {31'd0, busy}, 0);
    tick(1);
    chk("t3_ferr_end", {31'd0, frame_err}, 0);
    chk("t3_ferr_count", fe_count - fe_base, 1);
    chk("t3_valid_low", {31'd0, data_valid}, 0);
    tick(2);
    enable = 1'b0; tick(4);
    send_bits(8'h12, 8, 1'b1);
    tick(4);
    chk("t3_valid", {31'd0, data_valid}, 1);
    chk("t3_data", {24'd0, data_out}, 32'h12);
    ack_pulse();
    end_frame();

    // 4: completion coincides with DATA_ACK
    enable = 1'b0; tick(4);
    send_bits(8'h6B, 8, 1'b1);
    tick(H);
    send_bits(8'h94, 8, 1'b1);
    tick(3);
    data_ack = 1'b1; tick(1); data_ack = 1'b0;
    chk("t4_valid", {31'd0, data_valid}, 1);
    chk("t4_data", {24'd0, data_out}, 32'h94);
`ifdef SPI_RX_OVERRUN_EN
    chk("t4_no_ovr", {31'd0, overrun}, 0);
`endif
    ack_pulse();
    chk("t4_ack_clr", {31'd0, data_valid}, 0);
    end_frame();

    // 5: 11 then 22 without ACK
    enable = 1'b0; tick(4);
    send_bits(8'h11, 8, 1'b1);
    tick(H);
    send_bits(8'h22, 8, 1'b1);
    tick(4);
    chk("t5_valid", {31'd0, data_valid}, 1);
`ifdef SPI_RX_OVERRUN_EN
    chk("t5_data_kept", {24'd0, data_out}, 32'h11);
    chk("t5_ovr_set", {31'd0, overrun}, 1);
    ack_pulse();
    chk("t5_ovr_clr", {31'd0, overrun}, 0);
`else
    chk("t5_data_over", {24'd0, data_out}, 32'h22);
    ack_pulse();
`endif
    chk("t5_ack_clr", {31'd0, data_valid}, 0);
    end_frame();

    // 6: reset mid-frame, then 5A
    fe_base = fe_count;
    enable = 1'b0; tick(4);
    send_bits(8'hC7, 4, 1'b1);
    chk("t6_busy_pre", {31'd0, busy}, 1);
    rst = 1'b1; #1;
    chk("t6_rst_busy", {31'd0, busy}, 0);
    chk("t6_rst_data", {24'd0, data_out}, 0);
    chk("t6_rst_valid", {31'd0, data_valid}, 0);
    chk("t6_rst_ferr", {31'd0, frame_err}, 0);
    tick(2);
    rst = 1'b0;
    tick(4);
    send_bits(8'h5A, 8, 1'b1);
    tick(4);
    chk("t6_valid", {31'd0, data_valid}, 1);
    chk("t6_data", {24'd0, data_out}, 32'h5A);
    ack_pulse();
    end_frame();
    chk("t6_no_ferr", fe_count - fe_base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
